// File: rtl/i2c_slave_pkg.sv
// Shared types and helpers for the I2C target front end.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CMD,
    ST_CMD_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK
  } i2c_state_e;

  // Glitch-filter length in clk cycles, roughly 50 ns.
  function automatic int unsigned filt_len(input int unsigned clk_freq);
    return (clk_freq / 20 > 1) ? clk_freq / 20 : 1;
  endfunction

endpackage

// File: rtl/i2c_slave_filter.sv
// Synchronizes and glitch-filters SCL/SDA, then flags SCL edges and START/STOP.
module i2c_slave_filter #(
  parameter int unsigned FLT_LEN = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  localparam int unsigned CW = (FLT_LEN > 1) ? $clog2(FLT_LEN + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLT_LEN - 1);

  // index 0 = SCL, index 1 = SDA
  logic [1:0]    sync1_q, sync2_q, filt_q, prev_q;
  logic [CW-1:0] cnt_q [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      cnt_q[0] <= CNT_LOAD;
      cnt_q[1] <= CNT_LOAD;
    end else begin
      sync1_q <= {sda_i, scl_i};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        // Down-counter restarts whenever the raw level agrees with the filtered one.
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= CNT_LOAD;
        end else if (cnt_q[i] == '0) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= CNT_LOAD;
        end else begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  assign sda_o      = filt_q[1];
  assign scl_rise_o = filt_q[0] & ~prev_q[0];
  assign scl_fall_o = ~filt_q[0] & prev_q[0];
  assign start_o    = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
  assign stop_o     = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target: bus transactions to a single-register write strobe / read port.
//   state    | meaning
//   IDLE     | waiting for START
//   ADDR     | shifting in device address + R/W
//   ADDR_ACK | driving ACK for our address
//   CMD      | shifting in register pointer
//   CMD_ACK  | driving ACK for register pointer
//   WR       | shifting in a write data byte
//   WR_ACK   | driving ACK for a write data byte
//   RD       | driving read data, MSB first
//   RD_ACK   | SDA released, sampling master ACK/NACK
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] slave_addr,
  output logic [7:0] reg_addr,
  output logic       wr_en,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_oen
);

  logic sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic unused_addr_lsb;

  assign unused_addr_lsb = slave_addr[0];

  i2c_slave_filter #(.FLT_LEN(filt_len(CLK_FREQ))) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_pad_i),
    .sda_i      (sda_pad_i),
    .sda_o      (sda_f),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] data_out_q, data_out_d;
  logic       wr_en_q, wr_en_d;
  logic       oen_q, oen_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      reg_addr_q <= '0;
      data_out_q <= '0;
      wr_en_q    <= 1'b0;
      oen_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      data_out_q <= data_out_d;
      wr_en_q    <= wr_en_d;
      oen_q      <= oen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    data_out_d = data_out_q;
    wr_en_d    = 1'b0;
    oen_d      = oen_q;
    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      oen_d   = 1'b1;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      oen_d   = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_CMD, ST_WR: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_f};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            oen_d = 1'b0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == slave_addr[7:1]) begin
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IDLE;
                oen_d   = 1'b1;
              end
            end else if (state_q == ST_CMD) begin
              reg_addr_d = shift_q;
              state_d    = ST_CMD_ACK;
            end else begin
              data_out_d = shift_q;
              wr_en_d    = 1'b1;
              state_d    = ST_WR_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            // R/W bit is still in shift_q[0] from the address byte.
            if (shift_q[0]) begin
              state_d = ST_RD;
              shift_d = data_in;
              oen_d   = data_in[7];
              cnt_d   = 4'd1;
            end else begin
              state_d = ST_CMD;
              oen_d   = 1'b1;
            end
          end
        end
        ST_CMD_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            state_d = ST_WR;
            oen_d   = 1'b1;
          end
        end
        ST_RD: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = ST_RD_ACK;
              oen_d   = 1'b1;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oen_d   = shift_q[6];
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          // NACK leaves at the rising edge, so a falling edge here means ACK.
          if (scl_rise && sda_f) begin
            state_d = ST_IDLE;
          end else if (scl_fall) begin
            state_d = ST_RD;
            shift_d = data_in;
            oen_d   = data_in[7];
            cnt_d   = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_addr    = reg_addr_q;
  assign data_out    = data_out_q;
  assign wr_en       = wr_en_q;
  assign sda_pad_oen = oen_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level bench for i2c_slave: directed scenarios plus random transactions vs. a register model.
module tb_i2c_slave;

  localparam int QT = 200;  // quarter SCL period (clk period is 10)

  logic       clk;
  logic       rst_n;
  logic [7:0] slave_addr;
  logic [7:0] reg_addr;
  logic       wr_en;
  logic [7:0] data_out;
  logic [7:0] data_in;
  logic       scl_m, sda_m;
  logic       sda_pad_oen;
  logic       sda_line;
  logic [7:0] mem [256];

  assign sda_line = sda_m & sda_pad_oen;
  assign data_in  = mem[reg_addr];

  i2c_slave #(.CLK_FREQ(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .slave_addr  (slave_addr),
    .reg_addr    (reg_addr),
    .wr_en       (wr_en),
    .data_out    (data_out),
    .data_in     (data_in),
    .scl_pad_i   (scl_m),
    .sda_pad_i   (sda_line),
    .sda_pad_oen (sda_pad_oen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: log write strobes and count cycles with SDA pulled low.
  logic [7:0] wr_seen [$];
  int         oen_low_cnt = 0;
  logic       oen_prev = 1'b1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_seen.push_back(data_out);
      check_val("wr_en_vs_ack_start", {31'd0, oen_prev} * 2 + {31'd0, sda_pad_oen}, 32'd2);
    end
    if (sda_pad_oen === 1'b0) oen_low_cnt++;
    oen_prev = sda_pad_oen;
  end

  logic [7:0] m_reg_addr, m_data_out;

  task automatic qw;
    #(QT);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; qw;
    scl_m = 1'b1; qw;
    sda_m = 1'b0; qw;
    scl_m = 1'b0; qw;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; qw;
    scl_m = 1'b1; qw;
    sda_m = 1'b1; qw;
    qw;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; qw;
    scl_m = 1'b1; qw;
    qw;
    scl_m = 1'b0; qw;
  endtask

  task automatic get_ack(output logic ack);
    sda_m = 1'b1; qw;
    scl_m = 1'b1; qw;
    ack = ~sda_line; qw;
    scl_m = 1'b0; qw;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; qw;
      scl_m = 1'b1; qw;
      b[i] = sda_line; qw;
      scl_m = 1'b0; qw;
    end
    send_bit(~mack);
  endtask

  task automatic txn_write(input logic [7:0] addr, input logic [7:0] cmd, input logic [7:0] dat [$]);
    logic ack;
    bit   match = (addr[7:1] == slave_addr[7:1]);
    int   w0 = wr_seen.size();
    int   oen0 = oen_low_cnt;
    i2c_start;
    write_byte(addr, ack);
    check_val("addr_ack", {31'd0, ack}, {31'd0, match});
    write_byte(cmd, ack);
    check_val("cmd_ack", {31'd0, ack}, {31'd0, match});
    if (match) m_reg_addr = cmd;
    foreach (dat[i]) begin
      write_byte(dat[i], ack);
      check_val("data_ack", {31'd0, ack}, {31'd0, match});
      if (match) m_data_out = dat[i];
    end
    if (!match) check_val("nomatch_sda_low_cycles", oen_low_cnt - oen0, 0);
    i2c_stop;
    check_val("wr_count", wr_seen.size() - w0, match ? dat.size() : 0);
    for (int i = 0; i < dat.size() && w0 + i < wr_seen.size(); i++)
      check_val("wr_data", {24'd0, wr_seen[w0 + i]}, {24'd0, dat[i]});
    check_val("reg_addr", {24'd0, reg_addr}, {24'd0, m_reg_addr});
    check_val("data_out", {24'd0, data_out}, {24'd0, m_data_out});
  endtask

  task automatic txn_read(input logic [7:0] cmd, input int n);
    logic       ack;
    logic [7:0] b;
    int         w0 = wr_seen.size();
    i2c_start;
    write_byte({slave_addr[7:1], 1'b0}, ack);
    check_val("rd_waddr_ack", {31'd0, ack}, 32'd1);
    write_byte(cmd, ack);
    check_val("rd_cmd_ack", {31'd0, ack}, 32'd1);
    m_reg_addr = cmd;
    i2c_start;
    write_byte({slave_addr[7:1], 1'b1}, ack);
    check_val("rd_raddr_ack", {31'd0, ack}, 32'd1);
    for (int k = 0; k < n; k++) begin
      read_byte(k != n - 1, b);
      check_val("rd_data", {24'd0, b}, {24'd0, mem[m_reg_addr]});
    end
    i2c_stop;
    check_val("rd_no_wr", wr_seen.size() - w0, 0);
    check_val("rd_reg_addr", {24'd0, reg_addr}, {24'd0, m_reg_addr});
  endtask

  logic [7:0] dq [$];
  logic       ack;
  int         w0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    slave_addr = 8'h40;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rst_n = 1'b0;
    #100;
    check_val("rst_reg_addr", {24'd0, reg_addr}, 32'h00);
    check_val("rst_data_out", {24'd0, data_out}, 32'h00);
    check_val("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_val("rst_oen", {31'd0, sda_pad_oen}, 32'd1);
    rst_n = 1'b1;
    m_reg_addr = 8'h00;
    m_data_out = 8'h00;
    qw;

    // basic write
    dq = {8'hA5};
    txn_write(8'h40, 8'h01, dq);

    // read with repeated start, ACK then NACK
    mem[3] = 8'h5A;
    txn_read(8'h03, 2);

    // address mismatch
    dq = {8'hFF};
    txn_write(8'h42, 8'h01, dq);

    // burst write
    dq = {8'h11, 8'h22, 8'h33};
    txn_write(8'h40, 8'h02, dq);

    // STOP after 4 data bits; then bits without START must be ignored
    w0 = wr_seen.size();
    i2c_start;
    write_byte(8'h40, ack);
    check_val("abort_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h05, ack);
    check_val("abort_cmd_ack", {31'd0, ack}, 32'd1);
    m_reg_addr = 8'h05;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop;
    check_val("abort_no_wr", wr_seen.size() - w0, 0);
    check_val("abort_data_out", {24'd0, data_out}, {24'd0, m_data_out});
    check_val("abort_reg_addr", {24'd0, reg_addr}, {24'd0, m_reg_addr});
    scl_m = 1'b0; qw;
    write_byte(8'h40, ack);
    check_val("idle_ignores_bits", {31'd0, ack}, 32'd0);
    i2c_stop;

    // 20 ns SCL glitch inside the address byte
    i2c_start;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    scl_m = 1'b1; #20; scl_m = 1'b0; qw;
    for (int i = 4; i >= 0; i--) send_bit(1'b0);
    get_ack(ack);
    check_val("glitch_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h07, ack);
    check_val("glitch_cmd_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h3C, ack);
    check_val("glitch_data_ack", {31'd0, ack}, 32'd1);
    i2c_stop;
    m_reg_addr = 8'h07;
    m_data_out = 8'h3C;
    check_val("glitch_reg_addr", {24'd0, reg_addr}, {24'd0, m_reg_addr});
    check_val("glitch_data_out", {24'd0, data_out}, {24'd0, m_data_out});

    // reset while driving the read-address ACK
    i2c_start;
    for (int i = 7; i >= 0; i--) send_bit(i == 0 || i == 6);
    sda_m = 1'b1; qw;
    scl_m = 1'b1; qw;
    check_val("pre_rst_ack_drive", {31'd0, sda_pad_oen}, 32'd0);
    rst_n = 1'b0;
    #30;
    check_val("mid_rst_oen", {31'd0, sda_pad_oen}, 32'd1);
    check_val("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_val("mid_rst_reg_addr", {24'd0, reg_addr}, 32'h00);
    check_val("mid_rst_data_out", {24'd0, data_out}, 32'h00);
    rst_n = 1'b1;
    m_reg_addr = 8'h00;
    m_data_out = 8'h00;
    qw;
    scl_m = 1'b0; qw;
    check_val("post_rst_oen", {31'd0, sda_pad_oen}, 32'd1);
    i2c_stop;

    // random transactions, random device address
    for (int t = 0; t < 10; t++) begin
      int kind = $urandom_range(0, 2);
      int n = $urandom_range(1, 3);
      slave_addr = 8'($urandom_range(0, 255));
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom_range(0, 255)));
      case (kind)
        0: txn_write({slave_addr[7:1], 1'b0}, 8'($urandom_range(0, 255)), dq);
        1: txn_write({7'($urandom_range(0, 127)), 1'b0}, 8'($urandom_range(0, 255)), dq);
        default: txn_read(8'($urandom_range(0, 255)), n);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) front end that turns bus transactions into a simple register-port interface: one register address, a write strobe with data, and a read-data input. It sits below register-map wrappers such as the pca9538 GPIO expander. Those wrappers decode `reg_addr`, capture `data_out` on `wr_en`, and return read data on `data_in`. Open-drain SDA is handled by the pad level; this block only drives an output-enable.

## Interface
- `CLK_FREQ`, default 100: system clock frequency in MHz; sizes the input glitch filter.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `slave_addr`  in  8  device address; bits [7:1] are the 7-bit address, bit 0 is ignored.
- `reg_addr`  out  8  register pointer (command byte) last written by the master; reset 8'h00.
- `wr_en`  out  1  one-`clk` pulse per received data byte; reset 0.
- `data_out`  out  8  last data byte received from the master; reset 8'h00.
- `data_in`  in  8  read data for `reg_addr`, sampled by this block.
- `scl_pad_i`  in  1  SCL line.
- `sda_pad_i`  in  1  SDA line.
- `sda_pad_oen`  out  1  0 = pull SDA low, 1 = release; reset 1.

## Operation
- SCL/SDA pass through a 2-flop synchronizer, then a stability filter.
  - A new level is accepted only after it holds for `max(1, CLK_FREQ/20)` clocks (about 50 ns).
- Edge and condition detection (filtered signals only):
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
- Bit sampling: SDA is sampled on the SCL rising edge. `sda_pad_oen` changes only on the SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
  - ADDR_ACK:
    - Bits [7:1] equal `slave_addr[7:1]`: drive ACK. R/W=0 goes to CMD; R/W=1 goes to RD.
    - No match: release SDA and return to IDLE.
  - CMD → CMD_ACK: the byte loads `reg_addr` and is ACKed; then WR.
  - WR → WR_ACK: the byte loads `data_out`, pulses `wr_en`, and is ACKed; then WR again (unlimited bytes).
  - RD:
    - Load `data_in` into the shift register at the SCL falling edge that ends the previous ACK.
    - Drive bit 7 first; a 1 bit is released, a 0 bit is driven low.
    - After 8 bits, release SDA for the master ACK.
  - RD_ACK: on the SCL rising edge, SDA=0 (ACK) goes to RD with `data_in` re-sampled; SDA=1 (NACK) goes to IDLE.
- `reg_addr` does not auto-increment. Repeated writes and reads all target the same register until a new command byte arrives.
- A START in any state, including a repeated start, jumps to ADDR and releases SDA. `reg_addr` is retained.
- A STOP in any state goes to IDLE and releases SDA. A partial byte is discarded and `wr_en` is not asserted.
- General-call address 0x00 is not acknowledged unless `slave_addr[7:1]` is 0.

## Timing
- Input latency: 2 synchronizer clocks plus the filter length before an edge is recognised.
- ACK drive:
  - Asserted (`sda_pad_oen`=0) one `clk` after the filtered SCL falling edge that ends bit 8.
  - Released one `clk` after the filtered SCL falling edge that ends the ACK clock.
- `wr_en`: high for exactly one `clk`, in the same cycle ACK drive starts. `data_out` is valid in that cycle and holds until the next write byte.
- `reg_addr` updates in the same cycle as the CMD ACK drive.
- `data_in` is sampled once per read byte, at the falling-edge load point; it may change freely at other times.
- Asynchronous reset mid-transfer:
  - Immediately releases SDA, clears `wr_en`, and returns to IDLE.
  - Clears `reg_addr` and `data_out`.
  - The block ignores the bus until the next START.

## Structure
- Package `i2c_slave_pkg`: state enum and the filter-length function `max(1, CLK_FREQ/20)`.
- Sub-module `i2c_slave_filter`: synchronizer, stability filter, and SCL rise/fall plus START/STOP detection; one instance covers both lines.
- The top holds the FSM, bit counter, shift register and output registers.

## Test plan
- Write: START, 0x40, 0x01, 0xA5, STOP, with `slave_addr`=0x40.
  - Three ACKs.
  - `reg_addr`=0x01.
  - One `wr_en` pulse with `data_out`=0xA5.
- Read with repeated start: START, 0x40, 0x03, Sr, 0x41, with `data_in`=0x5A.
  - Read bytes: ACK, then NACK, then STOP.
  - SDA shows 0x5A MSB first for each byte.
  - No `wr_en`.
- Address mismatch: START, 0x42, 0x01, 0xFF with `slave_addr`=0x40.
  - `sda_pad_oen` stays 1 throughout; no `wr_en`; `reg_addr` unchanged.
- Burst write: 0x40, 0x02, 0x11, 0x22, 0x33.
  - Three `wr_en` pulses with `data_out` 0x11, 0x22, 0x33.
  - `reg_addr` stays 0x02.
- Aborts:
  - STOP after 4 data bits: no `wr_en`, IDLE.
  - `rst_n` low during read ACK: SDA released within reset, outputs reset.
- Glitch: 20 ns SCL pulse at CLK_FREQ=100: ignored, and the bit counter is unchanged.
